// File: rtl/relay_bus_pkg.sv
// Shared definitions for the MOV8 relay-bus sequencer: register codes,
// instruction field positions and FSM states.
`timescale 1ns/1ps
package relay_bus_pkg;

   localparam int DATA_BUS_WIDTH = 8;

   typedef enum logic [2:0] {A, B, C, D, M1, M2, X, Y} reg_code_e;

   localparam logic [1:0] MOV8_OPCODE = 2'b00;
   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 6;
   localparam int DST_MSB = 5;
   localparam int DST_LSB = 3;
   localparam int SRC_MSB = 2;
   localparam int SRC_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_LOAD,
      ST_RELEASE,
      ST_DONE
   } seq_state_e;

   function automatic logic [7:0] onehot8(input reg_code_e code);
      return 8'b1 << code;
   endfunction

endpackage

// File: rtl/mov8_bus_sequencer_cycle_timer.sv
// Loadable down-counter with a zero flag; times each relay phase.
`timescale 1ns/1ps
module cycle_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Holds at zero instead of wrapping so an idle timer stays expired.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/mov8_bus_sequencer.sv
// Sequences one MOV8 register-to-register transfer over the shared data
// bus with break-before-make timing of source drive and destination load.
`timescale 1ns/1ps
module mov8_bus_sequencer #(
   parameter int DATA_BUS_WIDTH = relay_bus_pkg::DATA_BUS_WIDTH,
   parameter int SETTLE_CYCLES  = 2,
   parameter int LOAD_CYCLES    = 2,
   parameter int RELEASE_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [7:0]                instr,
   input  logic [DATA_BUS_WIDTH-1:0] bus_data,
   output logic                      ready,
   output logic [7:0]                sel_out,
   output logic [7:0]                load_out,
   output logic                      clr,
   output logic                      done,
   output logic                      illegal,
   output logic [DATA_BUS_WIDTH-1:0] last_value
);
   import relay_bus_pkg::*;

   localparam int MAX_SL  = (SETTLE_CYCLES > LOAD_CYCLES) ? SETTLE_CYCLES : LOAD_CYCLES;
   localparam int MAX_CYC = (MAX_SL > RELEASE_CYCLES) ? MAX_SL : RELEASE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   if (SETTLE_CYCLES < 1 || LOAD_CYCLES < 1 || RELEASE_CYCLES < 1) begin : g_bad_cycles
      $error("mov8_bus_sequencer: cycle parameters must all be at least 1");
   end

   seq_state_e                state_q;
   reg_code_e                 dst_q;
   logic [7:0]                sel_q;
   logic [7:0]                load_q;
   logic                      clr_q;
   logic                      done_q;
   logic                      illegal_q;
   logic                      ready_q;
   logic [DATA_BUS_WIDTH-1:0] last_q;

   reg_code_e  src_w;
   reg_code_e  dst_w;
   logic       accept;
   logic       tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic       tmr_zero;

   assign src_w  = reg_code_e'(instr[SRC_MSB:SRC_LSB]);
   assign dst_w  = reg_code_e'(instr[DST_MSB:DST_LSB]);
   assign accept = start && (instr[OPC_MSB:OPC_LSB] == MOV8_OPCODE);

   // Each timed phase reloads the timer with (length-1) as it is entered.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: if (accept) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETTLE_CYCLES - 1);
         end
         ST_SELECT: if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(LOAD_CYCLES - 1);
         end
         ST_LOAD: if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(RELEASE_CYCLES - 1);
         end
         default: ;
      endcase
   end

   cycle_timer #(
      .WIDTH(CNT_W)
   ) u_timer (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         dst_q     <= A;
         sel_q     <= '0;
         load_q    <= '0;
         clr_q     <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         ready_q   <= 1'b1;
         last_q    <= '0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (start) begin
               if (accept) begin
                  state_q <= ST_SELECT;
                  ready_q <= 1'b0;
                  dst_q   <= dst_w;
                  // Self-move: nobody drives, the pull-down zeroes the register.
                  clr_q   <= (src_w == dst_w);
                  sel_q   <= (src_w == dst_w) ? 8'h00 : onehot8(src_w);
               end else begin
                  illegal_q <= 1'b1;
               end
            end
            ST_SELECT: if (tmr_zero) begin
               state_q <= ST_LOAD;
               load_q  <= onehot8(dst_q);
            end
            ST_LOAD: if (tmr_zero) begin
               state_q <= ST_RELEASE;
               load_q  <= '0;
               last_q  <= bus_data;
            end
            ST_RELEASE: if (tmr_zero) begin
               state_q <= ST_DONE;
               sel_q   <= '0;
               clr_q   <= 1'b0;
               done_q  <= 1'b1;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ready      = ready_q;
   assign sel_out    = sel_q;
   assign load_out   = load_q;
   assign clr        = clr_q;
   assign done       = done_q;
   assign illegal    = illegal_q;
   assign last_value = last_q;

endmodule

// File: tb/tb_mov8_bus_sequencer.sv
// Directed bench for mov8_bus_sequencer: default timing instance plus an
// S=1/L=3/R=2 instance, checked cycle by cycle against a timing model.
`timescale 1ns/1ps
module tb_mov8_bus_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] instr;
   logic [7:0] bus_data;

   logic       ready1, clr1, done1, illegal1;
   logic [7:0] sel1, load1, last1;
   logic       ready2, clr2, done2, illegal2;
   logic [7:0] sel2, load2, last2;

   logic       use2;
   logic       o_ready, o_clr, o_done, o_illegal;
   logic [7:0] o_sel, o_load, o_last;

   int total = 0;
   int bad   = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   mov8_bus_sequencer dut1 (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .bus_data(bus_data),
      .ready(ready1), .sel_out(sel1), .load_out(load1), .clr(clr1),
      .done(done1), .illegal(illegal1), .last_value(last1)
   );

   mov8_bus_sequencer #(
      .SETTLE_CYCLES(1), .LOAD_CYCLES(3), .RELEASE_CYCLES(2)
   ) dut2 (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .bus_data(bus_data),
      .ready(ready2), .sel_out(sel2), .load_out(load2), .clr(clr2),
      .done(done2), .illegal(illegal2), .last_value(last2)
   );

   always_comb begin
      o_ready   = use2 ? ready2   : ready1;
      o_sel     = use2 ? sel2     : sel1;
      o_load    = use2 ? load2    : load1;
      o_clr     = use2 ? clr2     : clr1;
      o_done    = use2 ? done2    : done1;
      o_illegal = use2 ? illegal2 : illegal1;
      o_last    = use2 ? last2    : last1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transfer from acceptance through a few idle cycles, checked per cycle.
   task automatic xfer(input logic [7:0] ins, input logic [7:0] bv,
                       input int s, input int l, input int r, input bit poke);
      int src, dst, last_k;
      logic same;
      logic [7:0] e_sel, e_load;
      src    = int'(ins[2:0]);
      dst    = int'(ins[5:3]);
      same   = (src == dst);
      last_k = s + l + r + 4;
      instr    = ins;
      bus_data = bv;
      start    = 1'b1;
      sb.push_back(bv);
      tick();
      start = 1'b0;
      instr = ~ins;
      for (int k = 1; k <= last_k; k++) begin
         if (poke && k == 3) begin
            start = 1'b1;
            instr = 8'h1A;
         end else begin
            start = 1'b0;
         end
         e_sel  = (k <= s + l + r && !same) ? (8'h01 << src) : 8'h00;
         e_load = (k > s && k <= s + l) ? (8'h01 << dst) : 8'h00;
         chk($sformatf("sel_k%0d", k),   o_sel,   e_sel);
         chk($sformatf("load_k%0d", k),  o_load,  e_load);
         chk($sformatf("clr_k%0d", k),   o_clr,   (same && k <= s + l + r));
         chk($sformatf("done_k%0d", k),  o_done,  (k == s + l + r + 1));
         chk($sformatf("ready_k%0d", k), o_ready, (k >= s + l + r + 2));
         if (o_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               chk("last_value", o_last, sb.pop_front());
            end
         end
         tick();
      end
      start = 1'b0;
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      use2     = 1'b0;
      reset    = 1'b1;
      start    = 1'b0;
      instr    = 8'h00;
      bus_data = 8'h00;
      tick();
      tick();
      chk("rst_ready",   o_ready,   1);
      chk("rst_sel",     o_sel,     0);
      chk("rst_load",    o_load,    0);
      chk("rst_clr",     o_clr,     0);
      chk("rst_done",    o_done,    0);
      chk("rst_illegal", o_illegal, 0);
      chk("rst_last",    o_last,    0);
      reset = 1'b0;
      tick();

      xfer(8'h0E, 8'h5A, 2, 2, 1, 1'b0);
      xfer(8'h3F, 8'h00, 2, 2, 1, 1'b0);

      instr = 8'h8C;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ill_pulse", o_illegal, 1);
      chk("ill_ready", o_ready,   1);
      chk("ill_sel",   o_sel,     0);
      chk("ill_load",  o_load,    0);
      tick();
      chk("ill_once",   o_illegal, 0);
      chk("ill_ready2", o_ready,   1);
      chk("ill_sel2",   o_sel,     0);
      chk("ill_last",   o_last,    8'h00);

      xfer(8'h0E, 8'h33, 2, 2, 1, 1'b1);

      instr    = 8'h0E;
      bus_data = 8'hA5;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("pre_rst_load", o_load, 8'h02);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_sel",   o_sel,   0);
      chk("abort_load",  o_load,  0);
      chk("abort_clr",   o_clr,   0);
      chk("abort_ready", o_ready, 1);
      chk("abort_done",  o_done,  0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("abort_nodone_%0d", k), o_done, 0);
         chk($sformatf("abort_idle_%0d", k), o_ready, 1);
      end

      instr = 8'h0E;
      start = 1'b1;
      reset = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      chk("rst_wins_ready", o_ready, 1);
      chk("rst_wins_sel",   o_sel,   0);
      tick();
      chk("rst_wins_sel2",  o_sel,   0);

      use2 = 1'b1;
      xfer(8'h21, 8'hC3, 1, 3, 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
